// File: rtl/au_arbiter.sv
// Round-robin arbiter sharing one 16-bit arithmetic unit among NUM_REQ requesters.
// Define AU_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module au_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [2*NUM_REQ-1:0]   req_ctrl,
  input  logic [16*NUM_REQ-1:0]  req_a,
  input  logic [16*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [1:0]             au_ctrl,
  output logic [15:0]            au_a,
  output logic [15:0]            au_b,
  input  logic [15:0]            au_result,
  input  logic                   au_v,
  input  logic                   au_n,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [15:0]            resp_data,
  output logic                   resp_z,
  output logic                   resp_v,
  output logic                   resp_n,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [ID_W-1:0] cur_id;
  logic [ID_W-1:0] win;
  logic            found;
  logic [1:0]      sel_ctrl;
  logic [15:0]     sel_a, sel_b;

`ifndef AU_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]      rr_ptr;
  logic [2*NUM_REQ-1:0] req_rot;
  logic [ID_W:0]        sum;
`endif

  always_comb begin
    found = 1'b0;
    win   = '0;
`ifdef AU_ARB_FIXED_PRIO_EN
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        win   = ID_W'(i);
      end
    end
`else
    // Rotate so bit 0 is the requester at rr_ptr; the first set bit wins.
    req_rot = {req, req} >> rr_ptr;
    sum     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, rr_ptr} + (ID_W+1)'(i);
        if (sum >= (ID_W+1)'(NUM_REQ))
          sum = sum - (ID_W+1)'(NUM_REQ);
        win   = sum[ID_W-1:0];
      end
    end
`endif
  end

  always_comb begin
    sel_ctrl = '0;
    sel_a    = '0;
    sel_b    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win == ID_W'(i)) begin
        sel_ctrl = req_ctrl[2*i +: 2];
        sel_a    = req_a[16*i +: 16];
        sel_b    = req_b[16*i +: 16];
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt        <= '0;
      au_ctrl    <= '0;
      au_a       <= '0;
      au_b       <= '0;
      cur_id     <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
      resp_z     <= 1'b0;
      resp_v     <= 1'b0;
      resp_n     <= 1'b0;
      busy       <= 1'b0;
`ifndef AU_ARB_FIXED_PRIO_EN
      rr_ptr     <= '0;
`endif
    end else begin
      busy <= (state_nx != IDLE);
      gnt  <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            au_ctrl <= sel_ctrl;
            au_a    <= sel_a;
            au_b    <= sel_b;
            cur_id  <= win;
            gnt     <= NUM_REQ'(1) << win;
          end
        end
        EXEC: begin
          resp_data  <= au_result;
          resp_v     <= au_v;
          resp_n     <= au_n;
          resp_z     <= (au_result == 16'h0000);
          resp_id    <= cur_id;
          resp_valid <= 1'b1;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
`ifndef AU_ARB_FIXED_PRIO_EN
            rr_ptr     <= (cur_id == ID_W'(NUM_REQ-1)) ? '0 : cur_id + ID_W'(1);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_au_arbiter.sv
// Self-checking bench for au_arbiter: directed test-plan cases plus randomized
// traffic against a transaction-level arbitration and saturating-AU model.
module tb_au_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [2*N-1:0]  req_ctrl;
  logic [16*N-1:0] req_a, req_b;
  logic [N-1:0]    gnt;
  logic [1:0]      au_ctrl;
  logic [15:0]     au_a, au_b, au_result;
  logic            au_v, au_n;
  logic            resp_valid, resp_ready;
  logic [1:0]      resp_id;
  logic [15:0]     resp_data;
  logic            resp_z, resp_v, resp_n, busy;

  au_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req(req), .req_ctrl(req_ctrl), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .au_ctrl(au_ctrl), .au_a(au_a), .au_b(au_b),
    .au_result(au_result), .au_v(au_v), .au_n(au_n),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_z(resp_z), .resp_v(resp_v), .resp_n(resp_n), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  int          ptr;
  logic [N-1:0] pending;
  logic [1:0]  op_ctrl [N];
  logic [15:0] op_a    [N];
  logic [15:0] op_b    [N];

  // Last observed response and grant time from run_op
  logic [15:0] obs_data;
  logic        obs_z, obs_v, obs_n;
  logic [1:0]  obs_id;
  int          gnt_cyc;

  // Behavioural AU: signed saturating add/sub, 16-bit or two 8-bit lanes. Returns {v, n, result}.
  function automatic logic [17:0] au_fn(input logic [1:0] c, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic        v;
    int s, lo_s, hi_s;
    v = 1'b0;
    if (!c[1]) begin
      s = {{16{a[15]}}, a};
      s = c[0] ? s - int'({{16{b[15]}}, b}) : s + int'({{16{b[15]}}, b});
      if (s > 32767)       begin r = 16'h7FFF; v = 1'b1; end
      else if (s < -32768) begin r = 16'h8000; v = 1'b1; end
      else                 r = 16'(s);
    end else begin
      lo_s = {{24{a[7]}}, a[7:0]};
      hi_s = {{24{a[15]}}, a[15:8]};
      lo_s = c[0] ? lo_s - int'({{24{b[7]}}, b[7:0]})  : lo_s + int'({{24{b[7]}}, b[7:0]});
      hi_s = c[0] ? hi_s - int'({{24{b[15]}}, b[15:8]}) : hi_s + int'({{24{b[15]}}, b[15:8]});
      if (lo_s > 127)       begin r[7:0] = 8'h7F; v = 1'b1; end
      else if (lo_s < -128) begin r[7:0] = 8'h80; v = 1'b1; end
      else                  r[7:0] = 8'(lo_s);
      if (hi_s > 127)       begin r[15:8] = 8'h7F; v = 1'b1; end
      else if (hi_s < -128) begin r[15:8] = 8'h80; v = 1'b1; end
      else                  r[15:8] = 8'(hi_s);
    end
    return {v, r[15], r};
  endfunction

  always_comb {au_v, au_n, au_result} = au_fn(au_ctrl, au_a, au_b);

  function automatic int pick(input logic [N-1:0] p, input int start);
`ifdef AU_ARB_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) if (p[k]) return k;
`else
    for (int k = 0; k < N; k++) if (p[(start + k) % N]) return (start + k) % N;
`endif
    return -1;
  endfunction

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req[i]              = pending[i];
      req_ctrl[2*i +: 2]  = op_ctrl[i];
      req_a[16*i +: 16]   = op_a[i];
      req_b[16*i +: 16]   = op_b[i];
    end
  endtask

  function automatic logic [15:0] rand_operand();
    case ($urandom_range(0, 4))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic new_op(input int i);
    op_ctrl[i] = 2'($urandom_range(0, 3));
    op_a[i]    = rand_operand();
    op_b[i]    = $urandom_range(0, 3) == 0 ? op_a[i] : rand_operand();
    pending[i] = 1'b1;
  endtask

  // One full transaction. Entry/exit: DUT idle, time is 1 unit after a rising edge.
  task automatic run_op(input int stall, input logic [N-1:0] add_mask, output int w);
    logic [17:0] e;
    logic [N-1:0] eg;
    apply();
    w  = pick(pending, ptr);
    eg = N'(1) << w;
    e  = au_fn(op_ctrl[w], op_a[w], op_b[w]);
    @(posedge clk); #1;
    gnt_cyc = cyc;
    n_checks++; if (gnt !== eg) begin n_fail++; $display("FAIL grant: gnt=%b want %b", gnt, eg); end
    n_checks++; if ({au_ctrl, au_a, au_b} !== {op_ctrl[w], op_a[w], op_b[w]}) begin
      n_fail++; $display("FAIL au_operands: %h/%h/%h want %h/%h/%h", au_ctrl, au_a, au_b, op_ctrl[w], op_a[w], op_b[w]); end
    n_checks++; if (busy !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL exec_state: busy=%b resp_valid=%b want 1/0", busy, resp_valid); end
    pending[w] = 1'b0;
    for (int i = 0; i < N; i++) if (add_mask[i] && !pending[i]) new_op(i);
    apply();
    @(posedge clk); #1;
    n_checks++; if ({resp_valid, gnt} !== {1'b1, {N{1'b0}}}) begin
      n_fail++; $display("FAIL resp_start: valid=%b gnt=%b want 1/0", resp_valid, gnt); end
    n_checks++; if ({resp_id, resp_v, resp_n, resp_data} !== {2'(w), e}) begin
      n_fail++; $display("FAIL resp_fields: id=%0d v=%b n=%b data=%h want id=%0d v=%b n=%b data=%h",
                         resp_id, resp_v, resp_n, resp_data, w, e[17], e[16], e[15:0]); end
    n_checks++; if (resp_z !== (e[15:0] == 16'h0)) begin
      n_fail++; $display("FAIL resp_z: got %b want %b", resp_z, e[15:0] == 16'h0); end
    obs_data = resp_data; obs_z = resp_z; obs_v = resp_v; obs_n = resp_n; obs_id = resp_id;
    for (int s = 0; s < stall; s++) begin
      resp_ready = 1'b0;
      @(posedge clk); #1;
      n_checks++; if ({resp_valid, gnt, busy, resp_id, resp_data, resp_z, resp_v, resp_n} !==
                      {1'b1, {N{1'b0}}, 1'b1, obs_id, obs_data, obs_z, obs_v, obs_n}) begin
        n_fail++; $display("FAIL stall_hold: valid=%b gnt=%b data=%h want 1/0/%h", resp_valid, gnt, resp_data, obs_data); end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    n_checks++; if ({resp_valid, busy, gnt, resp_data} !== {1'b0, 1'b0, {N{1'b0}}, obs_data}) begin
      n_fail++; $display("FAIL accept: valid=%b busy=%b gnt=%b data=%h want 0/0/0/%h", resp_valid, busy, gnt, resp_data, obs_data); end
`ifndef AU_ARB_FIXED_PRIO_EN
    ptr = (w + 1) % N;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; resp_ready = 1'b0; pending = '0; ptr = 0;
    for (int i = 0; i < N; i++) begin op_ctrl[i] = '0; op_a[i] = '0; op_b[i] = '0; end
    apply();
    repeat (2) @(posedge clk); #1;
    n_checks++; if ({gnt, au_ctrl, au_a, au_b, resp_valid, resp_id, resp_data, resp_z, resp_v, resp_n, busy} !== '0) begin
      n_fail++; $display("FAIL reset_values: gnt=%b au=%h/%h/%h valid=%b id=%0d data=%h busy=%b want all 0",
                         gnt, au_ctrl, au_a, au_b, resp_valid, resp_id, resp_data, busy); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if ({gnt, busy, resp_valid} !== '0) begin
      n_fail++; $display("FAIL idle_no_req: gnt=%b busy=%b valid=%b want 0", gnt, busy, resp_valid); end
  endtask

  task automatic test_directed();
    int w;
    op_ctrl[0] = 2'b00; op_a[0] = 16'h7FFF; op_b[0] = 16'h0001; pending = 4'b0001;
    run_op(0, '0, w);
    n_checks++; if ({obs_data, obs_v, obs_n, obs_z, obs_id} !== {16'h7FFF, 1'b1, 1'b0, 1'b0, 2'd0}) begin
      n_fail++; $display("FAIL add_sat: data=%h v=%b n=%b z=%b id=%0d want 7fff 1 0 0 0", obs_data, obs_v, obs_n, obs_z, obs_id); end
    op_ctrl[2] = 2'b01; op_a[2] = 16'h0005; op_b[2] = 16'h0005; pending = 4'b0100;
    run_op(0, '0, w);
    n_checks++; if ({obs_data, obs_z, obs_v, obs_id} !== {16'h0000, 1'b1, 1'b0, 2'd2}) begin
      n_fail++; $display("FAIL sub_zero: data=%h z=%b v=%b id=%0d want 0000 1 0 2", obs_data, obs_z, obs_v, obs_id); end
    op_ctrl[1] = 2'b10; op_a[1] = 16'h7F01; op_b[1] = 16'h0101; pending = 4'b0010;
    run_op(0, '0, w);
    n_checks++; if ({obs_data, obs_v, obs_id} !== {16'h7F02, 1'b1, 2'd1}) begin
      n_fail++; $display("FAIL padd: data=%h v=%b id=%0d want 7f02 1 1", obs_data, obs_v, obs_id); end
  endtask

  task automatic test_round_robin();
    int w, last_cyc;
    int exp_order [4];
`ifdef AU_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 3, 0, 3};
`endif
    test_reset();
    new_op(0); new_op(3);
    last_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      run_op(0, 4'b1001, w);
      n_checks++; if (w !== exp_order[k]) begin n_fail++; $display("FAIL rr_order[%0d]: winner=%0d want %0d", k, w, exp_order[k]); end
      if (k > 0) begin
        n_checks++; if (gnt_cyc - last_cyc !== 3) begin
          n_fail++; $display("FAIL rr_spacing[%0d]: %0d cycles want 3", k, gnt_cyc - last_cyc); end
      end
      last_cyc = gnt_cyc;
    end
    // Remaining requests drained so later tests start clean
    while (pending != '0) run_op(0, '0, w);
  endtask

  task automatic test_back_pressure();
    int w;
    pending = '0; new_op(2);
    run_op(5, 4'b0010, w);
    run_op(0, '0, w);
    n_checks++; if (w !== 1) begin n_fail++; $display("FAIL bp_next_grant: winner=%0d want 1", w); end
  endtask

  task automatic test_reset_mid_op();
    int w;
    pending = '0; new_op(1);
    run_op(0, '0, w);
    new_op(2); apply();
    @(posedge clk); #1;
    n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL midop_grant: gnt=%b want 0100", gnt); end
    rst = 1'b1; pending = '0; apply();
    @(posedge clk); #1;
    rst = 1'b0; ptr = 0;
    n_checks++; if ({gnt, resp_valid, busy, au_ctrl, au_a, au_b} !== '0) begin
      n_fail++; $display("FAIL midop_reset: gnt=%b valid=%b busy=%b au_a=%h want 0", gnt, resp_valid, busy, au_a); end
    resp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      n_checks++; if ({resp_valid, busy} !== 2'b00) begin
        n_fail++; $display("FAIL midop_no_resp: valid=%b busy=%b want 0/0", resp_valid, busy); end
    end
    resp_ready = 1'b0;
    new_op(0); new_op(3);
    run_op(0, '0, w);
    n_checks++; if (w !== 0) begin n_fail++; $display("FAIL midop_ptr_reset: winner=%0d want 0", w); end
    while (pending != '0) run_op(0, '0, w);
  endtask

  task automatic test_random();
    int w;
    logic [N-1:0] m;
    for (int k = 0; k < 60; k++) begin
      m = N'($urandom);
      for (int i = 0; i < N; i++) if (m[i] && !pending[i]) new_op(i);
      if (pending == '0) new_op(int'($urandom_range(0, N-1)));
      run_op(int'($urandom_range(0, 3)), N'($urandom), w);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; resp_ready = 1'b0; req = '0; req_ctrl = '0; req_a = '0; req_b = '0;
    test_reset();
    test_directed();
    test_round_robin();
    test_back_pressure();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
